// File: rtl/cpu_pc.sv
// cpu_pc: program counter for the single-issue core.
// Holds the fetch address and selects the next one each cycle. The choices are:
//   - sequential pc+4
//   - conditional branch
//   - jal
//   - jalr
//   - single-level interrupt entry and return
// All outputs are registered.
//
// Ports
//   clk              rising-edge clock, sole domain
//   reset            synchronous active-high reset
//   offset           signed branch/jal byte offset; full target (rs1+imm) for jalr
//   interrupt        level interrupt request
//   branch           current instruction is a conditional branch
//   zero             ALU zero flag; branch taken when branch & zero
//   jal              current instruction is jal
//   jalr             current instruction is jalr
//   pc               current fetch address
//   interrupt_grant  one-cycle pulse after interrupt entry
module cpu_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] offset,
  input  logic        interrupt,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal,
  input  logic        jalr,
  output logic [31:0] pc,
  output logic        interrupt_grant
);

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        in_isr_q, in_isr_d;
  logic        grant_q, grant_d;
  logic [31:0] rel_target;

  // Relative target shared by jal and taken branches; wraps modulo 2^32.
  assign rel_target = (pc_q + offset) & AlignMask;

  always_comb begin
    pc_d     = pc_q + 32'd4;
    epc_d    = epc_q;
    in_isr_d = in_isr_q;
    grant_d  = 1'b0;
    if (interrupt && !in_isr_q) begin
      // Entry abandons the instruction at pc; it is re-fetched on return.
      epc_d    = pc_q;
      pc_d     = IRQ_VECTOR;
      in_isr_d = 1'b1;
      grant_d  = 1'b1;
    end else if (!interrupt && in_isr_q) begin
      pc_d     = epc_q;
      in_isr_d = 1'b0;
    end else if (jalr) begin
      pc_d = offset & AlignMask;
    end else if (jal) begin
      pc_d = rel_target;
    end else if (branch && zero) begin
      pc_d = rel_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      epc_q    <= 32'h0;
      in_isr_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
      grant_q  <= grant_d;
    end
  end

  assign pc              = pc_q;
  assign interrupt_grant = grant_q;

endmodule

// File: tb/tb_cpu_pc.sv
module tb_cpu_pc;

  logic        clk;
  logic        reset;
  logic [31:0] offset;
  logic        interrupt;
  logic        branch;
  logic        zero;
  logic        jal;
  logic        jalr;
  logic [31:0] pc;
  logic        interrupt_grant;

  int checks;
  int failures;
  int step_no;
  bit done;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        grant;
  } exp_t;

  exp_t exp_q[$];

  cpu_pc #(
    .RESET_VECTOR(32'h0000_0000),
    .IRQ_VECTOR  (32'h0000_0010)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .offset         (offset),
    .interrupt      (interrupt),
    .branch         (branch),
    .zero           (zero),
    .jal            (jal),
    .jalr           (jalr),
    .pc             (pc),
    .interrupt_grant(interrupt_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
          failures++;
          $display("FAIL pc step %0d: got %08h expected %08h", e.id, pc, e.pc);
        end
        checks++;
        if (interrupt_grant !== e.grant) begin
          failures++;
          $display("FAIL grant step %0d: got %0b expected %0b", e.id, interrupt_grant, e.grant);
        end
      end
    end
  end

  // Drive one cycle of inputs on the falling edge and queue the state expected after the next
  // rising edge.
  task automatic step(input logic r, input logic irq, input logic br, input logic z,
                      input logic j, input logic jr, input logic [31:0] off,
                      input logic [31:0] e_pc, input logic e_grant);
    exp_t e;
    @(negedge clk);
    reset     = r;
    interrupt = irq;
    branch    = br;
    zero      = z;
    jal       = j;
    jalr      = jr;
    offset    = off;
    step_no++;
    e.id    = step_no;
    e.pc    = e_pc;
    e.grant = e_grant;
    exp_q.push_back(e);
  endtask

  // Plain sequential cycle, optionally with interrupt level.
  task automatic seq(input logic irq, input logic [31:0] e_pc, input logic e_grant);
    step(1'b0, irq, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_pc, e_grant);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    step_no   = 0;
    reset     = 1'b1;
    interrupt = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    offset    = 32'h0;

    // Reset held 10 cycles.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Sequential fetch up to 0x28.
    for (int i = 1; i <= 10; i++) seq(1'b0, 32'(4 * i), 1'b0);

    // Interrupt entry at 0x28, held high: no re-grant, handler advances.
    seq(1'b1, 32'h10, 1'b1);
    seq(1'b1, 32'h14, 1'b0);
    seq(1'b1, 32'h18, 1'b0);
    seq(1'b1, 32'h1C, 1'b0);
    // Drop: return to epc=0x28, then sequential.
    seq(1'b0, 32'h28, 1'b0);
    seq(1'b0, 32'h2C, 1'b0);
    // New request granted again.
    seq(1'b1, 32'h10, 1'b1);
    seq(1'b0, 32'h2C, 1'b0);
    seq(1'b0, 32'h30, 1'b0);

    // Branches from 0x40 (jalr used to reposition).
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -32'sd8, 32'h38, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -32'sd8, 32'h44, 1'b0);
    // jal / jalr / both.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h140, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 32'h200, 1'b0);

    // Control inputs ignored in entry and return cycles.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h10, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h200, 1'b0);

    // Wrap at the top of the address space, negative offset across zero, and alignment.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    seq(1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -32'sd8, 32'hFFFF_FFF8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0B, 32'h0, 1'b0);

    // Reset mid-handler, then interrupt on the first edge after release.
    seq(1'b1, 32'h10, 1'b1);
    seq(1'b1, 32'h14, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    seq(1'b1, 32'h10, 1'b1);
    seq(1'b0, 32'h0, 1'b0);
    seq(1'b0, 32'h4, 1'b0);

    // Drain: bounded wait for the monitor to consume everything.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
